// File: rtl/mul_wb_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : mul_wb_buffer_if
// Description : Bundle of the multiplier-side handshake and the register-file
//               write-back port of the multiplier write-back buffer.
//               slave  modport : the buffer itself
//               master modport : the environment (multiplier + register file)
//   mul_en_i     operation issued to the multiplier this cycle
//   mul_ready_i  multiplier result valid
//   mul_result_i multiplier result (32 bits)
//   rd_addr_i    destination register of the operation in flight
//   ex_ready_o   buffer can accept a result (to multiplier ex_ready_i)
//   flush_i      synchronous pipeline flush
//   wb_valid_o   head entry available for register-file write
//   wb_addr_o    head entry destination register
//   wb_data_o    head entry data
//   wb_ready_i   register-file write port accepts the head entry
//   count_o      number of stored entries
//   wb_cnt_o     number of completed write-backs (wraps at 16 bits)
// Revision    : 1.0 - initial release
// ============================================================================
interface mul_wb_buffer_if #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 2
);
  logic              mul_en_i;
  logic              mul_ready_i;
  logic [31:0]       mul_result_i;
  logic [RA_W-1:0]   rd_addr_i;
  logic              ex_ready_o;
  logic              flush_i;
  logic              wb_valid_o;
  logic [RA_W-1:0]   wb_addr_o;
  logic [31:0]       wb_data_o;
  logic              wb_ready_i;
  logic [CNT_W-1:0]  count_o;
  logic [15:0]       wb_cnt_o;

  modport slave (
    input  mul_en_i,
    input  mul_ready_i,
    input  mul_result_i,
    input  rd_addr_i,
    output ex_ready_o,
    input  flush_i,
    output wb_valid_o,
    output wb_addr_o,
    output wb_data_o,
    input  wb_ready_i,
    output count_o,
    output wb_cnt_o
  );

  modport master (
    output mul_en_i,
    output mul_ready_i,
    output mul_result_i,
    output rd_addr_i,
    input  ex_ready_o,
    output flush_i,
    input  wb_valid_o,
    input  wb_addr_o,
    input  wb_data_o,
    output wb_ready_i,
    input  count_o,
    input  wb_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/mul_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module      : mul_wb_buffer
// Description : Small FIFO between the multiplier result port and a
//               register-file write port. Results destined for x0 are
//               acknowledged but never stored. A flush empties the buffer
//               without touching the write-back counter.
// Ports       : clk  - single clock, rising edge
//               rst  - asynchronous active-high reset
//               bus  - mul_wb_buffer_if.slave (multiplier handshake,
//                      write-back port, occupancy and write-back count)
// Parameters  : DEPTH - number of entries (power of two, >= 2)
//               RA_W  - destination register address width
// Revision    : 1.0 - initial release
// ============================================================================
module mul_wb_buffer #(
  parameter int DEPTH = 2,
  parameter int RA_W  = 5
) (
  input wire logic          clk,
  input wire logic          rst,
  mul_wb_buffer_if.slave    bus
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;

  localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(DEPTH);
  localparam logic [RA_W-1:0]    c_reg_x0   = '0;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [RA_W-1:0]    r_mem_addr [DEPTH];
  logic [31:0]        r_mem_data [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic [15:0]        r_wb_cnt;

  // --------------------------------------------------------------------------
  // Handshake decode
  // --------------------------------------------------------------------------
  logic w_ex_ready;
  logic w_wb_valid;
  logic w_capture;
  logic w_store;
  logic w_pop;

  // Readiness depends only on stored occupancy so the multiplier never sees a
  // combinational path from the register-file side.
  assign w_ex_ready = (r_count != c_cnt_full);
  assign w_wb_valid = (r_count != '0);

  assign w_capture  = bus.mul_en_i & bus.mul_ready_i & w_ex_ready;
  // Results for x0 complete the handshake but are dropped here.
  assign w_store    = w_capture & (bus.rd_addr_i != c_reg_x0);
  assign w_pop      = w_wb_valid & bus.wb_ready_i;

  // --------------------------------------------------------------------------
  // Entry storage: no reset needed, contents are only visible while the
  // matching slot is counted as occupied.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_store) begin
      r_mem_addr[r_wr_ptr] <= bus.rd_addr_i;
      r_mem_data[r_wr_ptr] <= bus.mul_result_i;
    end
  end

  // --------------------------------------------------------------------------
  // Pointers and occupancy. Power-of-two depth lets the pointers wrap by
  // natural overflow.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_store) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      case ({w_store, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Write-back counter: a pop in a flush cycle is not a completed write.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_cnt <= '0;
    end else if (w_pop && !bus.flush_i) begin
      r_wb_cnt <= r_wb_cnt + 16'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: head fields are forced to zero while the buffer is empty.
  // --------------------------------------------------------------------------
  assign bus.ex_ready_o = w_ex_ready;
  assign bus.wb_valid_o = w_wb_valid;
  assign bus.wb_addr_o  = w_wb_valid ? r_mem_addr[r_rd_ptr] : '0;
  assign bus.wb_data_o  = w_wb_valid ? r_mem_data[r_rd_ptr] : '0;
  assign bus.count_o    = r_count;
  assign bus.wb_cnt_o   = r_wb_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mul_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_wb_buffer
// Description : Directed self-checking bench for mul_wb_buffer (DEPTH = 2,
//               RA_W = 5). Inputs change 1 ns after a rising edge; outputs
//               are checked in the same low-activity window.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_wb_buffer;

  localparam int DEPTH = 2;
  localparam int RA_W  = 5;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mul_wb_buffer_if #(.RA_W(RA_W), .CNT_W(CNT_W)) bus ();

  mul_wb_buffer #(.DEPTH(DEPTH), .RA_W(RA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cap(input logic en, input logic [RA_W-1:0] rd, input logic [31:0] d);
    bus.mul_en_i     = en;
    bus.mul_ready_i  = en;
    bus.rd_addr_i    = rd;
    bus.mul_result_i = d;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    drive_cap(1'b0, '0, '0);
    bus.flush_i    = 1'b0;
    bus.wb_ready_i = 1'b0;
    #1;

    // Reset values
    chk("rst_count",    32'(bus.count_o),    32'd0);
    chk("rst_valid",    32'(bus.wb_valid_o), 32'd0);
    chk("rst_addr",     32'(bus.wb_addr_o),  32'd0);
    chk("rst_data",     bus.wb_data_o,       32'd0);
    chk("rst_wbcnt",    32'(bus.wb_cnt_o),   32'd0);
    chk("rst_exready",  32'(bus.ex_ready_o), 32'd1);

    tick();
    rst = 1'b0;

    // Single pass-through, capture accepted first cycle after reset
    drive_cap(1'b1, 5'd7, 32'h0000_0006);
    bus.wb_ready_i = 1'b1;
    chk("pt_exready", 32'(bus.ex_ready_o), 32'd1);
    tick();
    drive_cap(1'b0, '0, '0);
    chk("pt_valid", 32'(bus.wb_valid_o), 32'd1);
    chk("pt_addr",  32'(bus.wb_addr_o),  32'd7);
    chk("pt_data",  bus.wb_data_o,       32'h6);
    tick();
    chk("pt_count", 32'(bus.count_o),  32'd0);
    chk("pt_wbcnt", 32'(bus.wb_cnt_o), 32'd1);

    // Fill to full, held result not captured, drain in order
    bus.wb_ready_i = 1'b0;
    drive_cap(1'b1, 5'd1, 32'hA);
    tick();
    drive_cap(1'b1, 5'd2, 32'hB);
    tick();
    chk("full_count",   32'(bus.count_o),    32'd2);
    chk("full_exready", 32'(bus.ex_ready_o), 32'd0);
    drive_cap(1'b1, 5'd3, 32'hC);
    tick();
    chk("full_hold_count", 32'(bus.count_o),   32'd2);
    chk("full_hold_addr",  32'(bus.wb_addr_o), 32'd1);
    chk("full_hold_data",  bus.wb_data_o,      32'hA);
    drive_cap(1'b0, '0, '0);
    bus.wb_ready_i = 1'b1;
    chk("drain_a_addr", 32'(bus.wb_addr_o), 32'd1);
    tick();
    chk("drain_b_addr",    32'(bus.wb_addr_o),  32'd2);
    chk("drain_b_data",    bus.wb_data_o,       32'hB);
    chk("drain_b_count",   32'(bus.count_o),    32'd1);
    chk("drain_b_exready", 32'(bus.ex_ready_o), 32'd1);
    tick();
    chk("drain_count", 32'(bus.count_o),    32'd0);
    chk("drain_wbcnt", 32'(bus.wb_cnt_o),   32'd3);
    chk("drain_valid", 32'(bus.wb_valid_o), 32'd0);

    // x0 discard
    bus.wb_ready_i = 1'b0;
    drive_cap(1'b1, 5'd0, 32'hDEAD_BEEF);
    chk("x0_exready", 32'(bus.ex_ready_o), 32'd1);
    tick();
    drive_cap(1'b0, '0, '0);
    chk("x0_count", 32'(bus.count_o),    32'd0);
    chk("x0_valid", 32'(bus.wb_valid_o), 32'd0);
    chk("x0_data",  bus.wb_data_o,       32'd0);

    // Simultaneous capture and pop
    drive_cap(1'b1, 5'd4, 32'h44);
    tick();
    chk("sim_pre_count", 32'(bus.count_o), 32'd1);
    drive_cap(1'b1, 5'd5, 32'h55);
    bus.wb_ready_i = 1'b1;
    tick();
    drive_cap(1'b0, '0, '0);
    chk("sim_count", 32'(bus.count_o),   32'd1);
    chk("sim_addr",  32'(bus.wb_addr_o), 32'd5);
    chk("sim_data",  bus.wb_data_o,      32'h55);
    chk("sim_wbcnt", 32'(bus.wb_cnt_o),  32'd4);
    tick();
    chk("sim_post_count", 32'(bus.count_o),  32'd0);
    chk("sim_post_wbcnt", 32'(bus.wb_cnt_o), 32'd5);

    // Flush with count 2, pop and capture requested together
    bus.wb_ready_i = 1'b0;
    drive_cap(1'b1, 5'd6, 32'h66);
    tick();
    drive_cap(1'b1, 5'd8, 32'h88);
    tick();
    chk("fl_pre_count", 32'(bus.count_o), 32'd2);
    drive_cap(1'b1, 5'd9, 32'h99);
    bus.wb_ready_i = 1'b1;
    bus.flush_i    = 1'b1;
    tick();
    chk("fl_count", 32'(bus.count_o),    32'd0);
    chk("fl_valid", 32'(bus.wb_valid_o), 32'd0);
    chk("fl_wbcnt", 32'(bus.wb_cnt_o),   32'd5);

    // Flush with count 1 while a capture is actually accepted
    bus.flush_i    = 1'b0;
    bus.wb_ready_i = 1'b0;
    drive_cap(1'b1, 5'd11, 32'hBB);
    tick();
    drive_cap(1'b1, 5'd10, 32'hAA);
    bus.wb_ready_i = 1'b1;
    bus.flush_i    = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    drive_cap(1'b0, '0, '0);
    chk("fl1_count", 32'(bus.count_o),  32'd0);
    chk("fl1_wbcnt", 32'(bus.wb_cnt_o), 32'd5);
    // Pointers restart from slot 0 after flush
    bus.wb_ready_i = 1'b0;
    drive_cap(1'b1, 5'd12, 32'hC0);
    tick();
    drive_cap(1'b0, '0, '0);
    chk("post_fl_addr", 32'(bus.wb_addr_o), 32'd12);
    chk("post_fl_data", bus.wb_data_o,      32'hC0);

    // Asynchronous reset between edges with count 1
    chk("ar_pre_count", 32'(bus.count_o), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_count",   32'(bus.count_o),    32'd0);
    chk("ar_valid",   32'(bus.wb_valid_o), 32'd0);
    chk("ar_addr",    32'(bus.wb_addr_o),  32'd0);
    chk("ar_data",    bus.wb_data_o,       32'd0);
    chk("ar_exready", 32'(bus.ex_ready_o), 32'd1);
    chk("ar_wbcnt",   32'(bus.wb_cnt_o),   32'd0);
    tick();
    rst = 1'b0;

    // Stream 0xFFFF pops, then one more to wrap the write-back counter
    bus.wb_ready_i = 1'b1;
    drive_cap(1'b1, 5'd1, 32'd0);
    tick();
    for (int i = 1; i <= 65535; i++) begin
      bus.mul_result_i = 32'(i);
      tick();
    end
    drive_cap(1'b0, '0, '0);
    chk("wrap_pre_wbcnt", 32'(bus.wb_cnt_o), 32'h0000_FFFF);
    chk("wrap_pre_count", 32'(bus.count_o),  32'd1);
    chk("wrap_pre_data",  bus.wb_data_o,     32'd65535);
    tick();
    chk("wrap_wbcnt", 32'(bus.wb_cnt_o), 32'd0);
    chk("wrap_count", 32'(bus.count_o),  32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mul_wb_buffer.md
MUL_WB_BUFFER -- requirements
Module: mul_wb_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, giving the number of result entries (power of two, at least 2).
REQ-002 The block SHALL have parameter RA_W, default 5, giving the destination register address width.
REQ-003 clk  in  1  single clock, all state on the rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 mul_en_i  in  1  operation issued to the multiplier this cycle (the multiplier's enable_i).
REQ-006 mul_ready_i  in  1  multiplier result valid (the multiplier's ready_o).
REQ-007 mul_result_i  in  32  multiplier result_o.
REQ-008 rd_addr_i  in  RA_W  destination register of the operation in flight.
REQ-009 ex_ready_o  out  1  downstream ready, drives the multiplier's ex_ready_i.
REQ-010 flush_i  in  1  synchronous pipeline flush.
REQ-011 wb_valid_o  out  1  head entry available for register-file write.
REQ-012 wb_addr_o  out  RA_W  head entry destination.
REQ-013 wb_data_o  out  32  head entry data.
REQ-014 wb_ready_i  in  1  register-file write port accepts the head entry.
REQ-015 count_o  out  clog2(DEPTH)+1  number of stored entries.
REQ-016 wb_cnt_o  out  16  count of completed write-backs.

Function
REQ-017 Definitions:
- capture = mul_en_i & mul_ready_i & ex_ready_o
- pop = wb_valid_o & wb_ready_i
REQ-018 ex_ready_o SHALL be (count_o != DEPTH), combinational from stored state only, with no path from wb_ready_i.
REQ-019 On capture with rd_addr_i != 0, the buffer SHALL write {rd_addr_i, mul_result_i} at the tail, visible at the head no earlier than the next cycle.
REQ-020 On capture with rd_addr_i == 0, the buffer SHALL complete the handshake and discard the data, leaving count unchanged.
REQ-021 wb_valid_o SHALL be (count_o != 0), and entries SHALL be presented in strict FIFO order.
REQ-022 wb_addr_o and wb_data_o SHALL be 0 whenever wb_valid_o is 0.
REQ-023 When the buffer is non-empty, head outputs SHALL hold stable until pop.
REQ-024 Count update rules:
- capture (stored) with pop: count unchanged
- capture (stored) only: count + 1
- pop only: count - 1
REQ-025 Read and write pointers SHALL wrap modulo DEPTH.
REQ-026 When full, capture SHALL be impossible because ex_ready_o is 0, and a pop in that cycle SHALL raise ex_ready_o on the next cycle.
REQ-027 wb_cnt_o SHALL increment by 1 on each pop and wrap from 0xFFFF to 0x0000.
REQ-028 flush_i SHALL set count and pointers to 0 on the next edge and override a same-cycle capture and pop.
REQ-029 wb_cnt_o SHALL NOT change on flush, and a pop coinciding with flush SHALL NOT be counted.
REQ-030 The block SHALL NOT drop a stored entry except by flush_i or rst.
REQ-031 The block SHALL NOT duplicate any stored entry.

Reset
REQ-032 While rst is high, outputs SHALL be:
- count_o = 0, wb_valid_o = 0, wb_addr_o = 0, wb_data_o = 0
- wb_cnt_o = 0, ex_ready_o = 1
- pointers cleared
REQ-033 Reset asserted mid-operation SHALL discard all stored entries immediately, without waiting for a clock edge.
REQ-034 After reset deasserts, the first capture SHALL be accepted in the same cycle.

Verification
REQ-035 Single pass-through:
- Stimulus: capture rd = 7, data = 0x0000_0006; wb_ready_i = 1.
- Response: next cycle wb_valid_o = 1, wb_addr_o = 7, wb_data_o = 6; one cycle later count_o = 0 and wb_cnt_o = 1.
REQ-036 Fill to full and drain (DEPTH = 2):
- Stimulus: wb_ready_i = 0; capture A (rd 1, 0xA), then B (rd 2, 0xB).
- Response: count_o = 2 and ex_ready_o = 0; a held mul_ready_i is not captured; after wb_ready_i = 1, output order is A then B.
REQ-037 x0 discard:
- Stimulus: capture rd = 0, data = 0xDEAD_BEEF.
- Response: ex_ready_o = 1 at capture, count_o stays 0, wb_valid_o stays 0.
REQ-038 Simultaneous capture and pop:
- Stimulus: count_o = 1; capture and pop in the same cycle.
- Response: count_o stays 1; head advances to the new entry.
REQ-039 Flush priority:
- Stimulus: count_o = 2; flush_i together with wb_ready_i = 1 and a capture.
- Response: next cycle count_o = 0, wb_valid_o = 0, wb_cnt_o unchanged.
REQ-040 Async reset and counter wrap:
- Stimulus: assert rst between edges with count_o = 1.
- Response: outputs take reset values before the next edge.
- Stimulus: preload wb_cnt_o = 0xFFFF, then one pop.
- Response: wb_cnt_o = 0x0000.
